// File: rtl/wdata_channel.sv
// wdata_channel: AXI4 write-data / write-response transmitter.
// Drains 1024-bit words from a FWFT FIFO into fixed-length W bursts gated by
// address-channel credits, counts B responses and reports done / error.
// Optional feature macro: BID_CHECK_EN (flag B responses whose BID != AXI_ID).
module wdata_channel #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned AXI_ID    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [1023:0]        m_axi_wdata,
  output logic [127:0]         m_axi_wstrb,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [ID_WIDTH-1:0]  m_axi_bid,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  input  logic                 start_pulse,
  input  logic [CNT_WIDTH-1:0] total_bursts,
  input  logic                 burst_grant,
  input  logic [1023:0]        fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  output logic                 wr_error,
  output logic                 wr_done
);

  localparam int unsigned DATA_W = 1024;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  total_q;
  logic [CNT_WIDTH-1:0]  credit_q;
  logic [CNT_WIDTH-1:0]  credit_d;
  logic [CNT_WIDTH-1:0]  loaded_bursts_q;
  logic [CNT_WIDTH-1:0]  sent_bursts_q;
  logic [CNT_WIDTH-1:0]  resp_cnt_q;
  logic [CNT_WIDTH-1:0]  resp_cnt_d;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  error_q;
  logic                  done_q;

  logic w_hs_c;
  logic b_hs_c;
  logic last_beat_c;
  logic load_c;
  logic grant_c;
  logic consume_c;
  logic final_w_c;
  logic bid_bad_c;
  logic b_err_c;

  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = {STRB_W{1'b1}};
  assign m_axi_wlast  = wlast_q;
  assign m_axi_wvalid = wvalid_q;
  assign m_axi_bready = (state_q == SEND) || (state_q == WAIT_B);
  assign wr_error     = error_q;
  assign wr_done      = done_q;
  // The FIFO head is consumed in the same cycle it is captured; never during reset.
  assign fifo_rd      = load_c && rst_n;

`ifdef BID_CHECK_EN
  assign bid_bad_c = (m_axi_bid != ID_WIDTH'(AXI_ID));
`else
  logic [ID_WIDTH-1:0] unused_bid_c;
  assign unused_bid_c = m_axi_bid ^ ID_WIDTH'(AXI_ID);
  assign bid_bad_c    = 1'b0;
`endif

  // Handshakes, output-register load decision and next counter values.
  always_comb begin
    w_hs_c      = m_axi_wvalid && m_axi_wready;
    b_hs_c      = m_axi_bvalid && m_axi_bready;
    last_beat_c = (beat_cnt_q == LAST_BEAT);
    load_c      = (state_q == SEND) && !fifo_empty && (!wvalid_q || m_axi_wready) &&
                  (loaded_bursts_q < total_q) &&
                  ((beat_cnt_q != '0) || (credit_q != '0) || burst_grant);
    grant_c     = burst_grant && (state_q != IDLE);
    consume_c   = load_c && (beat_cnt_q == '0);
    credit_d    = credit_q;
    if (grant_c && !consume_c) begin
      credit_d = credit_q + CNT_WIDTH'(1);
    end else if (!grant_c && consume_c) begin
      credit_d = credit_q - CNT_WIDTH'(1);
    end
    resp_cnt_d  = resp_cnt_q + CNT_WIDTH'(b_hs_c);
    final_w_c   = w_hs_c && wlast_q && ((sent_bursts_q + CNT_WIDTH'(1)) == total_q);
    b_err_c     = b_hs_c && ((m_axi_bresp != 2'b00) || bid_bad_c);
  end

  // Control FSM, counters and registered AXI / status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      total_q         <= '0;
      credit_q        <= '0;
      loaded_bursts_q <= '0;
      sent_bursts_q   <= '0;
      resp_cnt_q      <= '0;
      beat_cnt_q      <= '0;
      wdata_q         <= '0;
      wvalid_q        <= 1'b0;
      wlast_q         <= 1'b0;
      error_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      resp_cnt_q <= resp_cnt_d;
      done_q     <= 1'b0;
      if (b_err_c) begin
        error_q <= 1'b1;
      end

      if (load_c) begin
        wdata_q  <= fifo_dout;
        wvalid_q <= 1'b1;
        wlast_q  <= last_beat_c;
        if (last_beat_c) begin
          beat_cnt_q      <= '0;
          loaded_bursts_q <= loaded_bursts_q + CNT_WIDTH'(1);
        end else begin
          beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
        end
      end else if (w_hs_c) begin
        wvalid_q <= 1'b0;
        wlast_q  <= 1'b0;
      end

      if (w_hs_c && wlast_q) begin
        sent_bursts_q <= sent_bursts_q + CNT_WIDTH'(1);
      end

      case (state_q)
        IDLE: begin
          if (start_pulse) begin
            total_q         <= total_bursts;
            error_q         <= 1'b0;
            credit_q        <= '0;
            loaded_bursts_q <= '0;
            sent_bursts_q   <= '0;
            resp_cnt_q      <= '0;
            beat_cnt_q      <= '0;
            if (total_bursts != '0) begin
              state_q <= SEND;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (final_w_c) begin
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (resp_cnt_d == total_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
